echo_indication_serializer: RTL and testbench
=============================================

Name: echo_indication_serializer

Overview:
- Downstream neighbour of the Echo responder: consumes the indication$heard(meth, v) method calls and serializes each one into a 3-word, 32-bit packet on a host-bound word stream (out$enq).
- Decouples Echo from host-side backpressure with a small message FIFO.
- Each packet is a header word, then meth, then v.

Parameters:
- DEPTH, 4, message FIFO depth in messages; power of two, >= 2.
- CHANNEL_ID, 16'h0005, placed in header bits [31:16].

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, asynchronous, active-high.
- indication$heard__ENA  input  1  message enqueue strobe; only asserted while __RDY=1.
- indication$heard$meth  input  32  method id.
- indication$heard$v  input  32  value.
- indication$heard__RDY  output  1  FIFO not full.
- out$enq__ENA  output  1  word transfer this cycle.
- out$enq$v  output  32  word data.
- out$enq__RDY  input  1  sink can accept a word.
- pending  output  $clog2(DEPTH)+1  messages held in the FIFO, including the one being sent.

Behaviour:
- Reset:
  - Asynchronous on RST high: FIFO emptied, widx=WI_HDR, seq=0.
  - Outputs go immediately to indication$heard__RDY=1, out$enq__ENA=0, out$enq$v=0, pending=0.
  - A partially sent packet is abandoned; after reset the next packet starts with a header.
- Enqueue:
  - Push occurs when indication$heard__ENA && indication$heard__RDY.
  - indication$heard__RDY = (pending != DEPTH).
  - No bypass: when full, a pop in the same cycle does not enable a push. RDY rises the cycle after the pop.
- Word index FSM, widx:
  - States are WI_HDR -> WI_METH -> WI_V -> WI_HDR, advancing only on a transfer.
  - valid = (pending != 0).
  - out$enq__ENA = valid && out$enq__RDY (combinational, atomicc-style initiator).
- out$enq$v is combinational from the FIFO head:
  - WI_HDR: {CHANNEL_ID, seq_field[7:0], 8'd3}.
  - WI_METH: head.meth.
  - WI_V: head.v.
  - 0 when !valid.
- Pop: a transfer in WI_V pops the FIFO head and returns widx to WI_HDR.
- Pending update:
  - Push and pop in the same cycle: pending unchanged.
  - Push only: +1. Pop only: -1.
- Latency: a message pushed into an empty FIFO at cycle N presents its header at cycle N+1. Minimum 3 cycles per packet; back-to-back packets have no gap.
- Stall: while out$enq__RDY=0, the word and widx hold. The ENA/RDY timing does not affect packet contents.
- Head message is stable for the whole packet; it is never overwritten by later pushes.
- FIFO pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro ECHO_SER_SEQNUM_EN.
- Defined:
  - seq_field = 8-bit packet counter, reset 0.
  - Increments on each WI_V transfer; wraps 255 -> 0.
- Undefined: seq_field = 8'h00 and no counter register exists.

Decomposition:
- Package echo_ser_pkg:
  - widx enum (WI_HDR=0, WI_METH=1, WI_V=2).
  - PKT_LEN=3.
  - Header field offsets: CHAN_LSB=16, SEQ_LSB=8, LEN_LSB=0.
  - struct echo_msg_t {meth[31:0], v[31:0]}.
- Sub-module msg_fifo:
  - Generic synchronous FIFO of echo_msg_t.
  - Parameter DEPTH, asynchronous active-high reset.
  - Exposes head, count, push, pop.
- The serializer FSM stays in the top level.

Test Plan:
- Single message (meth=32'h1, v=32'hDEAD), out$enq__RDY=1 throughout:
  - Words 32'h0005_0003, 32'h1, 32'hDEAD on consecutive cycles, starting 1 cycle after the push.
  - pending goes 1 -> 0 after the third word.
- Push 4 messages back-to-back with out$enq__RDY=0:
  - indication$heard__RDY drops after the 4th push; pending=4.
  - Release RDY: 12 words, no gaps, in order; RDY returns 1 the cycle after the first pop.
- Toggle out$enq__RDY 1,0,0,1,0,1,1 during a packet: data holds during stalls; the packet is delivered intact, exactly 3 ENA pulses.
- Full FIFO while popping the last word: simultaneous ENA on heard is not possible because RDY=0; pending goes 4 -> 3.
- Assert RST after the METH word:
  - Immediately ENA=0 and pending=0.
  - Next pushed message emits a fresh header, not a v word.
- With ECHO_SER_SEQNUM_EN defined, send 257 packets: header[15:8] runs 0x00..0xFF, then 0x00; header[7:0]=3 throughout.

Source files
------------

// File: rtl/echo_ser_pkg.sv
// Shared types and header layout for the Echo indication serializer.
package echo_ser_pkg;

    typedef enum logic [1:0] {
        WI_HDR  = 2'd0,
        WI_METH = 2'd1,
        WI_V    = 2'd2
    } widx_e;

    localparam int PKT_LEN  = 3;
    localparam int CHAN_LSB = 16;
    localparam int SEQ_LSB  = 8;
    localparam int LEN_LSB  = 0;

    typedef struct packed {
        logic [31:0] meth;
        logic [31:0] v;
    } echo_msg_t;

endpackage

// File: rtl/msg_fifo.sv
// Synchronous FIFO of echo messages; the head entry is visible without a pop.
module msg_fifo
    import echo_ser_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  echo_msg_t                data_i,
    input  logic                     pop_i,
    output echo_msg_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    echo_msg_t      mem_q [DEPTH];
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  rptr_q;
    logic [AW:0]    count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PTR_ONE;
            if (pop_i)  rptr_q <= rptr_q + PTR_ONE;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/echo_indication_serializer.sv
// Serializes indication_heard calls into 3-word packets (header, meth, v) on out_enq.
// Optional macro ECHO_SER_SEQNUM_EN adds an 8-bit packet counter in header bits [15:8].
module echo_indication_serializer
    import echo_ser_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] CHANNEL_ID = 16'h0005
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       indication_heard__ENA,
    input  logic [31:0]                indication_heard_meth,
    input  logic [31:0]                indication_heard_v,
    output logic                       indication_heard__RDY,
    output logic                       out_enq__ENA,
    output logic [31:0]                out_enq_v,
    input  logic                       out_enq__RDY,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    widx_e           widx_q;
    echo_msg_t       inMsg;
    echo_msg_t       head;
    logic [CW-1:0]   count;
    logic            valid;
    logic            xfer;
    logic            push;
    logic            pop;
    logic [7:0]      seqField;
    logic [31:0]     hdrWord;
    logic [31:0]     outWord;

    assign inMsg = '{meth: indication_heard_meth, v: indication_heard_v};

    // No bypass: readiness is taken from the registered count only.
    assign indication_heard__RDY = (count != FULL);
    assign push         = indication_heard__ENA && indication_heard__RDY;
    assign valid        = (count != '0);
    assign out_enq__ENA = valid && out_enq__RDY;
    assign xfer         = out_enq__ENA;
    assign pop          = xfer && (widx_q == WI_V);
    assign pending      = count;

    msg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .data_i  (inMsg),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            widx_q <= WI_HDR;
        end else if (xfer) begin
            case (widx_q)
                WI_HDR:  widx_q <= WI_METH;
                WI_METH: widx_q <= WI_V;
                default: widx_q <= WI_HDR;
            endcase
        end
    end

`ifdef ECHO_SER_SEQNUM_EN
    logic [7:0] seq_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) seq_q <= 8'd0;
        else if (pop) seq_q <= seq_q + 8'd1;
    end

    assign seqField = seq_q;
`else
    assign seqField = 8'h00;
`endif

    assign hdrWord = (32'(CHANNEL_ID) << CHAN_LSB) |
                     (32'(seqField)   << SEQ_LSB)  |
                     (32'(PKT_LEN)    << LEN_LSB);

    always_comb begin
        outWord = '0;
        if (valid) begin
            case (widx_q)
                WI_HDR:  outWord = hdrWord;
                WI_METH: outWord = head.meth;
                WI_V:    outWord = head.v;
                default: outWord = '0;
            endcase
        end
    end

    assign out_enq_v = outWord;

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Directed, table-driven bench for echo_indication_serializer (DEPTH=4, CHANNEL_ID=5).
module tb_echo_indication_serializer;

`ifdef ECHO_SER_SEQNUM_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif
    localparam logic [31:0] HDR = 32'h0005_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        heardEna = 1'b0;
    logic [31:0] heardMeth = '0;
    logic [31:0] heardV = '0;
    logic        heardRdy;
    logic        enqEna;
    logic [31:0] enqV;
    logic        enqRdy = 1'b0;
    logic [2:0]  pending;

    int nChecks = 0;
    int nFails  = 0;
    int seqModel = 0;

    echo_indication_serializer #(.DEPTH(4), .CHANNEL_ID(16'h0005)) dut (
        .CLK                   (clk),
        .RST                   (rst),
        .indication_heard__ENA (heardEna),
        .indication_heard_meth (heardMeth),
        .indication_heard_v    (heardV),
        .indication_heard__RDY (heardRdy),
        .out_enq__ENA          (enqEna),
        .out_enq_v             (enqV),
        .out_enq__RDY          (enqRdy),
        .pending               (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic [31:0] meth;
        logic [31:0] v;
        logic        outRdy;
        logic        expEna;
        logic [31:0] expV;
        bit          isHdr;
        bit          pktEnd;
        int          expPend;
        logic        expRdy;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic ena, logic [31:0] meth, logic [31:0] v, logic outRdy,
                                logic expEna, logic [31:0] expV, bit isHdr, bit pktEnd,
                                int expPend, logic expRdy);
        vec_t r;
        r.ena = ena; r.meth = meth; r.v = v; r.outRdy = outRdy;
        r.expEna = expEna; r.expV = expV; r.isHdr = isHdr; r.pktEnd = pktEnd;
        r.expPend = expPend; r.expRdy = expRdy;
        return r;
    endfunction

    function automatic logic [31:0] hdrFor(int seq);
        logic [7:0] s;
        s = SEQ_ON ? 8'(seq) : 8'h00;
        return HDR | (32'(s) << 8);
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic ena, input logic [31:0] meth,
                                 input logic [31:0] v, input logic outRdy);
        @(negedge clk);
        heardEna  = ena;
        heardMeth = meth;
        heardV    = v;
        enqRdy    = outRdy;
        #1;
    endtask

    task automatic checkField(input string name, input string field,
                              input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("[TB] FAIL %s.%s got %0h want %0h", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input logic expEna, input logic [31:0] expV,
                               input int expPend, input logic expRdy);
        checkField(name, "ena", 32'(enqEna), 32'(expEna));
        checkField(name, "word", enqV, expV);
        checkField(name, "pending", 32'(pending), 32'(expPend));
        checkField(name, "rdy", 32'(heardRdy), 32'(expRdy));
    endtask

    initial begin
        logic [31:0] words[3];
        int          idx;
        int          pulses;
        logic        pat[7];

        // Single packet, then four queued while the sink stalls, then drained.
        vecs[0]  = mk(0, 0, 0, 1,              0, 0, 0, 0, 0, 1);
        vecs[1]  = mk(1, 32'h1, 32'hDEAD, 1,   0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 1,              1, HDR, 1, 0, 1, 1);
        vecs[3]  = mk(0, 0, 0, 1,              1, 32'h1, 0, 0, 1, 1);
        vecs[4]  = mk(0, 0, 0, 1,              1, 32'hDEAD, 0, 1, 1, 1);
        vecs[5]  = mk(0, 0, 0, 1,              0, 0, 0, 0, 0, 1);
        vecs[6]  = mk(1, 32'h10, 32'hA0, 0,    0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(1, 32'h11, 32'hB1, 0,    0, HDR, 1, 0, 1, 1);
        vecs[8]  = mk(1, 32'h12, 32'hC2, 0,    0, HDR, 1, 0, 2, 1);
        vecs[9]  = mk(1, 32'h13, 32'hD3, 0,    0, HDR, 1, 0, 3, 1);
        vecs[10] = mk(0, 0, 0, 0,              0, HDR, 1, 0, 4, 0);
        vecs[11] = mk(0, 0, 0, 1,              1, HDR, 1, 0, 4, 0);
        vecs[12] = mk(0, 0, 0, 1,              1, 32'h10, 0, 0, 4, 0);
        vecs[13] = mk(0, 0, 0, 1,              1, 32'hA0, 0, 1, 4, 0);
        vecs[14] = mk(0, 0, 0, 1,              1, HDR, 1, 0, 3, 1);
        vecs[15] = mk(0, 0, 0, 1,              1, 32'h11, 0, 0, 3, 1);
        vecs[16] = mk(0, 0, 0, 1,              1, 32'hB1, 0, 1, 3, 1);
        vecs[17] = mk(0, 0, 0, 1,              1, HDR, 1, 0, 2, 1);
        vecs[18] = mk(0, 0, 0, 1,              1, 32'h12, 0, 0, 2, 1);
        vecs[19] = mk(0, 0, 0, 1,              1, 32'hC2, 0, 1, 2, 1);
        vecs[20] = mk(0, 0, 0, 1,              1, HDR, 1, 0, 1, 1);
        vecs[21] = mk(0, 0, 0, 1,              1, 32'h13, 0, 0, 1, 1);
        vecs[22] = mk(0, 0, 0, 1,              1, 32'hD3, 0, 1, 1, 1);
        vecs[23] = mk(0, 0, 0, 1,              0, 0, 0, 0, 0, 1);

        #2;
        checkOutput("reset", 0, 0, 0, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].ena, vecs[i].meth, vecs[i].v, vecs[i].outRdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].expEna,
                        vecs[i].isHdr ? hdrFor(seqModel) : vecs[i].expV,
                        vecs[i].expPend, vecs[i].expRdy);
            if (vecs[i].pktEnd) seqModel++;
        end

        // Sink toggles readiness mid-packet; words must hold while stalled.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        applyStimulus(1, 32'h20, 32'hE0, 0);
        checkOutput("stallPush", 0, 0, 0, 1);
        words[0] = hdrFor(seqModel);
        words[1] = 32'h20;
        words[2] = 32'hE0;
        idx = 0;
        pulses = 0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, 0, pat[k]);
            if (enqEna) pulses++;
            if (idx < 3) begin
                checkOutput($sformatf("stall%0d", k), pat[k], words[idx], 1, 1);
                if (pat[k]) idx++;
                if (idx == 3) seqModel++;
            end else begin
                checkOutput($sformatf("stall%0d", k), 0, 0, 0, 1);
            end
        end
        checkField("stallPulses", "count", 32'(pulses), 32'd3);

        // Reset after the METH word has been taken abandons the packet.
        applyStimulus(1, 32'h30, 32'hF0, 1);
        checkOutput("rstPush", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rstHdr", 1, hdrFor(seqModel), 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rstMeth", 1, 32'h30, 1, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstAsync", 0, 0, 0, 1);
        seqModel = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 32'h40, 32'h60, 1);
        checkOutput("postRstPush", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("postRstHdr", 1, hdrFor(seqModel), 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("postRstMeth", 1, 32'h40, 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("postRstV", 1, 32'h60, 1, 1);
        seqModel++;
        applyStimulus(0, 0, 0, 1);
        checkOutput("postRstIdle", 0, 0, 0, 1);

`ifdef ECHO_SER_SEQNUM_EN
        // Counter wrap: 257 packets from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 257; p++) begin
            applyStimulus(1, 32'(p), ~32'(p), 1);
            applyStimulus(0, 0, 0, 1);
            checkField($sformatf("seqHdr%0d", p), "word", enqV,
                       {16'h0005, 8'(p), 8'd3});
            applyStimulus(0, 0, 0, 1);
            applyStimulus(0, 0, 0, 1);
            checkField($sformatf("seqV%0d", p), "word", enqV, ~32'(p));
        end
`endif

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
